// File: rtl/exec_ctrl_if.sv
// Instruction-memory fetch handshake between exec_ctrl (master) and the
// instruction memory (slave).
interface exec_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/exec_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for RV32I OP and OP-IMM.
// Optional retired-instruction counter enabled by the CTRL_INSTRET_EN macro.
module exec_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    exec_ctrl_if.master imem,
    output logic        reg_write,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] imm,
    output logic        busy,
    output logic        illegal
`ifdef CTRL_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;

    // Only 32-bit OP and OP-IMM encodings are accepted.
    function automatic logic is_legal(input logic [31:0] ins);
        logic ok;
        ok = 1'b0;
        if (ins[1:0] == 2'b11) begin
            ok = (ins[6:2] == OPC_OP) || (ins[6:2] == OPC_OP_IMM);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // I-type immediate for OP-IMM; register-register ops carry no immediate.
    function automatic logic [31:0] decode_imm(input logic [31:0] ins);
        logic [31:0] val;
        val = 32'h0000_0000;
        if (ins[6:2] == OPC_OP_IMM) begin
            val = {{20{ins[31]}}, ins[31:20]};
        end else begin
            val = 32'h0000_0000;
        end
        return val;
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  state_nx_s;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic        fetch_hs_s;
    logic        imem_req_r;
    logic        reg_write_r;
    logic        busy_r;
    logic        illegal_r;
    logic [4:0]  rs1_r;
    logic [4:0]  rs2_r;
    logic [4:0]  rd_r;
    logic [4:0]  opcode_r;
    logic [2:0]  func3_r;
    logic [6:0]  func7_r;
    logic [31:0] imm_r;

    assign fetch_hs_s = imem_req_r & imem.imem_ready;

    // Next-state selection for the instruction sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_FETCH;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (fetch_hs_s) begin
                    state_nx_s = S_DECODE;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_legal(ir_r)) begin
                    state_nx_s = S_EXEC;
                end else begin
                    state_nx_s = S_HALT;
                end
            end
            S_EXEC:  state_nx_s = S_WB;
            S_WB:    state_nx_s = S_FETCH;
            S_HALT:  state_nx_s = S_HALT;
            default: state_nx_s = S_HALT;
        endcase
    end

    // State, PC and instruction register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= 32'h0000_0000;
        end else begin
            state_r <= state_nx_s;
            if (state_r == S_WB) begin
                pc_r <= pc_r + 32'd4;
            end
            if ((state_r == S_FETCH) && fetch_hs_s) begin
                ir_r <= imem.imem_rdata;
            end
        end
    end

    // Strobes are registered from the next state so each is glitch-free
    // and valid for exactly the cycles the FSM spends in that state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            imem_req_r  <= 1'b0;
            reg_write_r <= 1'b0;
            busy_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            imem_req_r  <= (state_nx_s == S_FETCH);
            reg_write_r <= (state_nx_s == S_WB) && (rd_r != 5'd0);
            busy_r      <= (state_nx_s == S_FETCH) || (state_nx_s == S_DECODE) ||
                           (state_nx_s == S_EXEC)  || (state_nx_s == S_WB);
            illegal_r   <= (state_nx_s == S_HALT);
        end
    end

    // Field outputs load once per instruction and hold until the next decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs1_r    <= 5'd0;
            rs2_r    <= 5'd0;
            rd_r     <= 5'd0;
            opcode_r <= 5'd0;
            func3_r  <= 3'd0;
            func7_r  <= 7'd0;
            imm_r    <= 32'h0000_0000;
        end else if (state_r == S_DECODE) begin
            rs1_r    <= ir_r[19:15];
            rs2_r    <= ir_r[24:20];
            rd_r     <= ir_r[11:7];
            opcode_r <= ir_r[6:2];
            func3_r  <= ir_r[14:12];
            func7_r  <= ir_r[31:25];
            imm_r    <= decode_imm(ir_r);
        end
    end

`ifdef CTRL_INSTRET_EN
    logic [31:0] instret_r;

    // Retired-instruction count; rd=x0 writes still retire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instret_r <= 32'h0000_0000;
        end else if (state_r == S_WB) begin
            instret_r <= instret_r + 32'd1;
        end
    end

    assign instret = instret_r;
`endif

    assign imem.imem_req  = imem_req_r;
    assign imem.imem_addr = pc_r;
    assign reg_write      = reg_write_r;
    assign busy           = busy_r;
    assign illegal        = illegal_r;
    assign rs1            = rs1_r;
    assign rs2            = rs2_r;
    assign rd             = rd_r;
    assign opcode         = opcode_r;
    assign func3          = func3_r;
    assign func7          = func7_r;
    assign imm            = imm_r;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed scenarios plus randomized
// instruction streams with random fetch stalls, checked against a cycle model.
module tb_exec_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        reg_write;
    logic [4:0]  rs1, rs2, rd, opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        busy, illegal;
`ifdef CTRL_INSTRET_EN
    logic [31:0] instret;
    logic [31:0] exp_instret = 32'd0;
`endif

    exec_ctrl_if bus ();

    exec_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .imem      (bus),
        .reg_write (reg_write),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .imm       (imm),
        .busy      (busy),
        .illegal   (illegal)
`ifdef CTRL_INSTRET_EN
        ,
        .instret   (instret)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_pc     = RESET_PC;
    logic [61:0] exp_fields = 62'd0;
    wire  [61:0] dut_fields = {rs1, rs2, rd, opcode, func3, func7, imm};

    // Reference decode: fields straight from the instruction word.
    function automatic logic [61:0] model_fields(input logic [31:0] ins);
        logic [31:0] m_imm;
        if (ins[6:2] == 5'b00100) m_imm = 32'($signed(ins[31:20]));
        else                      m_imm = 32'd0;
        return {ins[19:15], ins[24:20], ins[11:7], ins[6:2], ins[14:12], ins[31:25], m_imm};
    endfunction

    function automatic logic model_legal(input logic [31:0] ins);
        return (ins[1:0] == 2'b11) && ((ins[6:2] == 5'b01100) || (ins[6:2] == 5'b00100));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        #3;
        checks++;
        if ({bus.imem_req, reg_write, busy, illegal} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000", {bus.imem_req, reg_write, busy, illegal});
        end
        checks++;
        if (bus.imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RESET_PC);
        end
        checks++;
        if (dut_fields !== 62'd0) begin
            failures++;
            $display("FAIL reset_fields got=%h exp=0", dut_fields);
        end
        tick();
        reset = 1'b1;
        bus.imem_ready = 1'b1;
        tick();
        tick();
        bus.imem_ready = 1'b0;
        checks++;
        if ({bus.imem_req, busy} !== 2'b00) begin
            failures++;
            $display("FAIL idle_wait got=%b exp=00", {bus.imem_req, busy});
        end
        exp_pc     = RESET_PC;
        exp_fields = 62'd0;
`ifdef CTRL_INSTRET_EN
        exp_instret = 32'd0;
        checks++;
        if (instret !== 32'd0) begin
            failures++;
            $display("FAIL reset_instret got=%h exp=0", instret);
        end
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({bus.imem_req, busy} !== 2'b11) begin
            failures++;
            $display("FAIL start_fetch got=%b exp=11", {bus.imem_req, busy});
        end
    endtask

    // Entered and left at a FETCH-cycle sample point.
    task automatic run_instr(input logic [31:0] ins, input int stalls);
        logic legal;
        legal = model_legal(ins);
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_pc}) begin
            failures++;
            $display("FAIL fetch_addr got=%b/%h exp=1/%h", bus.imem_req, bus.imem_addr, exp_pc);
        end
        bus.imem_ready = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            bus.imem_rdata = $urandom;
            tick();
            checks++;
            if ({bus.imem_req, bus.imem_addr, reg_write} !== {1'b1, exp_pc, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold got=%b/%h exp=1/%h", bus.imem_req, bus.imem_addr, exp_pc);
            end
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = ins;
        tick();
        // DECODE: ready is meaningless here and must not disturb anything.
        bus.imem_ready = 1'($urandom_range(0, 1));
        bus.imem_rdata = $urandom;
        checks++;
        if ({bus.imem_req, busy, reg_write, illegal} !== 4'b0100 || dut_fields !== exp_fields) begin
            failures++;
            $display("FAIL decode_cycle got=%b/%h exp=0100/%h",
                     {bus.imem_req, busy, reg_write, illegal}, dut_fields, exp_fields);
        end
        tick();
        if (!legal) begin
            bus.imem_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({illegal, busy, bus.imem_req, reg_write} !== 4'b1000) begin
                    failures++;
                    $display("FAIL halt_state got=%b exp=1000", {illegal, busy, bus.imem_req, reg_write});
                end
                tick();
            end
`ifdef CTRL_INSTRET_EN
            checks++;
            if (instret !== exp_instret) begin
                failures++;
                $display("FAIL halt_instret got=%h exp=%h", instret, exp_instret);
            end
`endif
            return;
        end
        exp_fields = model_fields(ins);
        checks++;
        if ({busy, reg_write} !== 2'b10 || dut_fields !== exp_fields) begin
            failures++;
            $display("FAIL exec_cycle got=%b/%h exp=10/%h", {busy, reg_write}, dut_fields, exp_fields);
        end
        bus.imem_ready = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if ({busy, reg_write, bus.imem_req} !== {1'b1, (ins[11:7] != 5'd0), 1'b0}) begin
            failures++;
            $display("FAIL wb_cycle got=%b exp=1%b0", {busy, reg_write, bus.imem_req}, (ins[11:7] != 5'd0));
        end
        bus.imem_ready = 1'($urandom_range(0, 1));
        tick();
        bus.imem_ready = 1'b0;
        exp_pc = exp_pc + 32'd4;
`ifdef CTRL_INSTRET_EN
        exp_instret = exp_instret + 32'd1;
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL instret got=%h exp=%h", instret, exp_instret);
        end
`endif
        checks++;
        if ({reg_write, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, exp_pc}) begin
            failures++;
            $display("FAIL next_fetch got=%b/%h exp=01/%h", {reg_write, bus.imem_req}, bus.imem_addr, exp_pc);
        end
    endtask

    task automatic test_addi();
        do_start();
        run_instr(32'h0050_0093, 0);
        checks++;
        if ({rd, rs1, opcode, imm} !== {5'd1, 5'd0, 5'b00100, 32'd5} || bus.imem_addr !== 32'd4) begin
            failures++;
            $display("FAIL addi_fields got=%h/%h exp=%h/4",
                     {rd, rs1, opcode, imm}, bus.imem_addr, {5'd1, 5'd0, 5'b00100, 32'd5});
        end
    endtask

    task automatic test_add();
        run_instr(32'h0020_81B3, 0);
        checks++;
        if (dut_fields !== {5'd1, 5'd2, 5'd3, 5'b01100, 3'd0, 7'd0, 32'd0}) begin
            failures++;
            $display("FAIL add_fields got=%h exp=%h", dut_fields, {5'd1, 5'd2, 5'd3, 5'b01100, 3'd0, 7'd0, 32'd0});
        end
    endtask

    task automatic test_stall();
        run_instr(32'h4010_5213, 3);
        run_instr(32'h0010_0013, 1);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int n = 0; n < 30; n++) begin
            ins = $urandom;
            ins[1:0] = 2'b11;
            ins[6:2] = ($urandom_range(0, 1) == 0) ? 5'b01100 : 5'b00100;
            if ($urandom_range(0, 5) == 0) ins[11:7] = 5'd0;
            run_instr(ins, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_exec();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0020_81B3;
        tick();
        bus.imem_ready = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.imem_req, reg_write, busy, illegal, bus.imem_addr, dut_fields} !== {4'b0000, RESET_PC, 62'd0}) begin
            failures++;
            $display("FAIL reset_in_exec got=%b/%h/%h", {bus.imem_req, reg_write, busy, illegal}, bus.imem_addr, dut_fields);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.imem_req, reg_write, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=000", {bus.imem_req, reg_write, busy});
        end
        exp_pc     = RESET_PC;
        exp_fields = 62'd0;
`ifdef CTRL_INSTRET_EN
        exp_instret = 32'd0;
`endif
    endtask

    task automatic test_illegal();
        logic [31:0] ins;
        do_start();
        run_instr(32'h0050_0093, 0);
        run_instr(32'h0000_006F, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({illegal, busy, bus.imem_req} !== 3'b100) begin
            failures++;
            $display("FAIL halt_start_ignored got=%b exp=100", {illegal, busy, bus.imem_req});
        end
        test_reset();
        do_start();
        do ins = $urandom; while (model_legal(ins));
        run_instr(ins, int'($urandom_range(0, 2)));
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add();
        test_stall();
        test_random();
        test_reset_exec();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
